// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO responder.
// No logic here; frame field widths, opcodes and FSM state encoding.
// Imported by mdio_sync and mdio_responder.
package mdio_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_OP,
        ST_PHYAD,
        ST_REGAD,
        ST_TA,
        ST_WDATA,
        ST_RDATA,
        ST_SKIP
    } state_t;

    localparam logic [1:0] MDIO_OP_READ  = 2'b10;
    localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
    localparam logic [1:0] MDIO_ST       = 2'b01;

    localparam int PHYAD_W   = 5;
    localparam int REGAD_W   = 5;
    localparam int DATA_W    = 16;
    // Bits a non-addressed PHY lets pass after REGAD: TA (2) + data (16).
    localparam int SKIP_BITS = 18;

endpackage

// File: rtl/mdio_sync.sv
// Purpose: 2-flop synchronizers for MDC/MDIO plus MDC rising-edge pulse (bit_en).
// Latency: MDC pin edge -> bit_en high 3 clk later, mdio_smp aligned with it.
// Backpressure: none; one bit_en per MDC rising edge, glitches < 1 clk may be lost.
module mdio_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic mdc,
    input  logic mdio,
    output logic bit_en,
    output logic mdio_smp
);

    logic [1:0] mdc_ff;
    logic [1:0] mdio_ff;
    logic       mdc_prev;

    // Identical synchronizer chains keep MDIO aligned with the MDC edge; both idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdc_ff   <= 2'b11;
            mdio_ff  <= 2'b11;
            mdc_prev <= 1'b1;
            bit_en   <= 1'b0;
            mdio_smp <= 1'b1;
        end else begin
            mdc_ff   <= {mdc_ff[0], mdc};
            mdio_ff  <= {mdio_ff[0], mdio};
            mdc_prev <= mdc_ff[1];
            bit_en   <= mdc_ff[1] & ~mdc_prev;
            mdio_smp <= mdio_ff[1];
        end
    end

endmodule

// File: rtl/mdio_responder.sv
// Purpose: PHY-side Clause-22 MDIO responder decoding frames into a single-cycle register port.
// Latency: MDC pin edge -> MDIO drive 4 clk; reg_rd at last REGAD bit, reg_wr after 16th data bit.
// Backpressure: none; reg_rdata must be valid within 4 clk of reg_rd. Option: MDIO_RESPONDER_PREAMBLE_SUPPRESS_EN.
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR     = 5'd1,
    parameter int         PREAMBLE_MIN = 32
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic               mdio_mdc,
    input  logic               mdio_in,
    output logic               mdio_out,
    output logic               mdio_oen,
    output logic [REGAD_W-1:0] reg_addr,
    output logic [DATA_W-1:0]  reg_wdata,
    output logic               reg_wr,
    output logic               reg_rd,
    input  logic [DATA_W-1:0]  reg_rdata
);

`ifdef MDIO_RESPONDER_PREAMBLE_SUPPRESS_EN
    localparam bit SUPPRESS_EN = 1'b1;
`else
    localparam bit SUPPRESS_EN = 1'b0;
`endif

    localparam int             PW      = $clog2(PREAMBLE_MIN + 1);
    localparam logic [PW-1:0]  PRE_SAT = PW'(PREAMBLE_MIN);

    logic bit_en;
    logic smp;

    mdio_sync u_sync (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .mdc      (mdio_mdc),
        .mdio     (mdio_in),
        .bit_en   (bit_en),
        .mdio_smp (smp)
    );

    state_t               state_q, state_d;
    logic [PW-1:0]        pre_q, pre_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [DATA_W-1:0]    sh_q, sh_d;
    logic [1:0]           op_q, op_d;
    logic [PHYAD_W-1:0]   phy_q, phy_d;
    logic                 sup_q, sup_d;
    logic                 out_d, oen_d, wr_d, rd_d;
    logic [REGAD_W-1:0]   addr_d;
    logic [DATA_W-1:0]    wdata_d;

    logic [1:0]           op_nx;
    logic [DATA_W-1:0]    sh_in;
    logic                 pre_ok;

    assign op_nx = {op_q[0], smp};
    assign sh_in = {sh_q[DATA_W-2:0], smp};
    // After a completed matching frame the suppressed build accepts a start after a single idle one.
    assign pre_ok = (pre_q == PRE_SAT) || (SUPPRESS_EN && sup_q && (pre_q != '0));

    // State and output registers; reset releases MDIO at once and drops any partial frame.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            cnt_q     <= '0;
            sh_q      <= '0;
            op_q      <= '0;
            phy_q     <= '0;
            sup_q     <= 1'b0;
            mdio_out  <= 1'b1;
            mdio_oen  <= 1'b1;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            op_q      <= op_d;
            phy_q     <= phy_d;
            sup_q     <= sup_d;
            mdio_out  <= out_d;
            mdio_oen  <= oen_d;
            reg_addr  <= addr_d;
            reg_wdata <= wdata_d;
            reg_wr    <= wr_d;
            reg_rd    <= rd_d;
        end
    end

    // Frame decoder: advances one field bit per bit_en; strobes default low so they last one cycle.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        op_d    = op_q;
        phy_d   = phy_q;
        sup_d   = sup_q;
        out_d   = mdio_out;
        oen_d   = mdio_oen;
        addr_d  = reg_addr;
        wdata_d = reg_wdata;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        if (bit_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (smp) begin
                        if (pre_q != PRE_SAT) pre_d = pre_q + 1'b1;
                    end else if (pre_ok) begin
                        // Counter restarts here so every frame end sees it at zero.
                        state_d = ST_START;
                        pre_d   = '0;
                        sup_d   = 1'b0;
                    end else begin
                        pre_d = '0;
                    end
                end
                ST_START: begin
                    cnt_d   = '0;
                    state_d = (smp == MDIO_ST[0]) ? ST_OP : ST_IDLE;
                end
                ST_OP: begin
                    op_d = op_nx;
                    if (cnt_q == 5'd1) begin
                        cnt_d   = '0;
                        state_d = (op_nx == MDIO_OP_READ || op_nx == MDIO_OP_WRITE) ? ST_PHYAD : ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                ST_PHYAD: begin
                    phy_d = {phy_q[PHYAD_W-2:0], smp};
                    if (cnt_q == 5'(PHYAD_W - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_REGAD;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                ST_REGAD: begin
                    sh_d = sh_in;
                    if (cnt_q == 5'(REGAD_W - 1)) begin
                        cnt_d  = '0;
                        addr_d = sh_in[REGAD_W-1:0];
                        if (phy_q != PHY_ADDR) begin
                            state_d = ST_SKIP;
                        end else begin
                            state_d = ST_TA;
                            rd_d    = (op_q == MDIO_OP_READ);
                        end
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                ST_TA: begin
                    if (op_q == MDIO_OP_READ) begin
                        if (cnt_q == 5'd0) begin
                            // Drive the second TA bit as 0 and capture the read data.
                            sh_d  = reg_rdata;
                            oen_d = 1'b0;
                            out_d = 1'b0;
                            cnt_d = 5'd1;
                        end else begin
                            // D15 must be on the pin before the master's next rising MDC.
                            out_d   = sh_q[DATA_W-1];
                            sh_d    = {sh_q[DATA_W-2:0], 1'b0};
                            cnt_d   = '0;
                            state_d = ST_RDATA;
                        end
                    end else if (cnt_q == 5'd1) begin
                        cnt_d   = '0;
                        state_d = ST_WDATA;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                ST_WDATA: begin
                    sh_d = sh_in;
                    if (cnt_q == 5'(DATA_W - 1)) begin
                        wdata_d = sh_in;
                        wr_d    = 1'b1;
                        sup_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                ST_RDATA: begin
                    if (cnt_q == 5'(DATA_W - 1)) begin
                        // Master is sampling D0 on this edge; release the line.
                        oen_d   = 1'b1;
                        out_d   = 1'b1;
                        sup_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        out_d = sh_q[DATA_W-1];
                        sh_d  = {sh_q[DATA_W-2:0], 1'b0};
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                ST_SKIP: begin
                    if (cnt_q == 5'(SKIP_BITS - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    pre_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_responder.sv
// Bench: acts as the MDIO master and checks decoded register accesses and read data.
// A frame-level model decides which frames must be accepted and what the master must see.
// Random frames cover preamble length, opcode and PHY address mixes.
module tb_mdio_responder;
    import mdio_pkg::*;

    localparam int         H    = 10;
    localparam int         P    = 2 * H;
    localparam logic [4:0] MYPHY = 5'd1;
    localparam int         PMIN = 32;
`ifdef MDIO_RESPONDER_PREAMBLE_SUPPRESS_EN
    localparam bit SUP = 1'b1;
`else
    localparam bit SUP = 1'b0;
`endif

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        mdio_mdc = 1'b0;
    logic        m_drv = 1'b1;
    logic        mdio_in;
    logic        mdio_out, mdio_oen;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wdata, reg_rdata;
    logic        reg_wr, reg_rd;
    logic [15:0] mem [32];

    assign reg_rdata = mem[reg_addr];
    assign mdio_in   = mdio_oen ? m_drv : mdio_out;

    always #5 clk_clk = ~clk_clk;

    mdio_responder #(.PHY_ADDR(MYPHY), .PREAMBLE_MIN(PMIN)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .mdio_mdc      (mdio_mdc),
        .mdio_in       (mdio_in),
        .mdio_out      (mdio_out),
        .mdio_oen      (mdio_oen),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_wr        (reg_wr),
        .reg_rd        (reg_rd),
        .reg_rdata     (reg_rdata)
    );

    int checks = 0;
    int failures = 0;

    int          wr_cnt, rd_cnt, oen_low, pulse_err;
    logic [4:0]  wr_addr, rd_addr;
    logic [15:0] wr_data, rd_seen;
    logic        ta_seen, oen_before, oen_after;
    logic        prev_wr = 1'b0, prev_rd = 1'b0;
    bit          sup_flag = 1'b0;

    always @(negedge clk_clk) begin
        if (reg_wr) begin wr_cnt++; wr_addr = reg_addr; wr_data = reg_wdata; end
        if (reg_rd) begin rd_cnt++; rd_addr = reg_addr; end
        if ((reg_wr && prev_wr) || (reg_rd && prev_rd) || (reg_wr && reg_rd)) pulse_err++;
        if (!mdio_oen) oen_low++;
        prev_wr = reg_wr;
        prev_rd = reg_rd;
    end

    initial begin
        repeat (95000) @(posedge clk_clk);
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // Frame-level reference: accepted iff enough preamble ones; strobes only for valid op to this PHY.
    task automatic model(input int npre, input logic [1:0] op, input logic [4:0] phy,
                         output int e_wr, output int e_rd);
        int need;
        bit ok;
        need = (SUP && sup_flag) ? 1 : PMIN;
        e_wr = 0;
        e_rd = 0;
        if (npre >= need) begin
            ok = (op == MDIO_OP_READ || op == MDIO_OP_WRITE) && (phy == MYPHY);
            e_wr = (ok && op == MDIO_OP_WRITE) ? 1 : 0;
            e_rd = (ok && op == MDIO_OP_READ) ? 1 : 0;
            sup_flag = ok;
        end
    endtask

    task automatic mdc_bit(input logic b, output logic s);
        m_drv = b;
        repeat (H) @(negedge clk_clk);
        mdio_mdc = 1'b1;
        s = mdio_in;
        repeat (H) @(negedge clk_clk);
        mdio_mdc = 1'b0;
    endtask

    task automatic do_reset();
        reset_reset_n = 1'b0;
        repeat (3) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        repeat (3) @(negedge clk_clk);
        sup_flag = 1'b0;
    endtask

    task automatic run_frame(input bit sep, input int npre, input logic [1:0] op, input logic [4:0] phy,
                             input logic [4:0] ra, input logic [15:0] wd, input int abort_at);
        logic [31:0] fr;
        logic s;
        fr = {MDIO_ST, op, phy, ra, (op == MDIO_OP_READ) ? 2'b11 : 2'b10,
              (op == MDIO_OP_READ) ? 16'hFFFF : wd};
        wr_cnt = 0; rd_cnt = 0; oen_low = 0; pulse_err = 0;
        rd_seen = '0; ta_seen = 1'b1;
        if (sep) mdc_bit(1'b0, s);
        for (int i = 0; i < npre; i++) mdc_bit(1'b1, s);
        for (int i = 0; i < 32; i++) begin
            if (i == abort_at) begin
                oen_before = mdio_oen;
                reset_reset_n = 1'b0;
                #1;
                oen_after = mdio_oen;
                repeat (3) @(negedge clk_clk);
                reset_reset_n = 1'b1;
                sup_flag = 1'b0;
                break;
            end
            mdc_bit(fr[31-i], s);
            if (i == 15) ta_seen = s;
            if (i >= 16) rd_seen = {rd_seen[14:0], s};
        end
        m_drv = 1'b1;
        repeat (6) @(negedge clk_clk);
    endtask

    task automatic test_reset();
        reset_reset_n = 1'b0;
        repeat (3) @(negedge clk_clk);
        checks++; if ({mdio_oen, mdio_out} !== 2'b11) begin failures++; $display("FAIL reset_mdio: got %b expected 11", {mdio_oen, mdio_out}); end
        checks++; if ({reg_wr, reg_rd} !== 2'b00) begin failures++; $display("FAIL reset_strobes: got %b expected 00", {reg_wr, reg_rd}); end
        checks++; if ({reg_addr, reg_wdata} !== 21'd0) begin failures++; $display("FAIL reset_regs: got %h expected 0", {reg_addr, reg_wdata}); end
        reset_reset_n = 1'b1;
        repeat (3) @(negedge clk_clk);
    endtask

    task automatic test_write();
        int e_wr, e_rd;
        model(32, MDIO_OP_WRITE, 5'd1, e_wr, e_rd);
        run_frame(1'b1, 32, MDIO_OP_WRITE, 5'd1, 5'h04, 16'hA5C3, -1);
        checks++; if (wr_cnt !== 1 || rd_cnt !== 0) begin failures++; $display("FAIL write_count: got wr=%0d rd=%0d expected 1 0", wr_cnt, rd_cnt); end
        checks++; if (wr_addr !== 5'h04) begin failures++; $display("FAIL write_addr: got %h expected 04", wr_addr); end
        checks++; if (wr_data !== 16'hA5C3) begin failures++; $display("FAIL write_data: got %h expected a5c3", wr_data); end
        checks++; if (oen_low !== 0 || pulse_err !== 0) begin failures++; $display("FAIL write_oen: got oen_low=%0d perr=%0d expected 0 0", oen_low, pulse_err); end
    endtask

    task automatic test_read();
        int e_wr, e_rd;
        mem[2] = 16'h0141;
        model(32, MDIO_OP_READ, 5'd1, e_wr, e_rd);
        run_frame(1'b1, 32, MDIO_OP_READ, 5'd1, 5'h02, 16'h0, -1);
        checks++; if (rd_cnt !== 1 || wr_cnt !== 0) begin failures++; $display("FAIL read_count: got rd=%0d wr=%0d expected 1 0", rd_cnt, wr_cnt); end
        checks++; if (rd_addr !== 5'h02) begin failures++; $display("FAIL read_addr: got %h expected 02", rd_addr); end
        checks++; if (ta_seen !== 1'b0) begin failures++; $display("FAIL read_ta: got %b expected 0", ta_seen); end
        checks++; if (rd_seen !== 16'h0141) begin failures++; $display("FAIL read_data: got %h expected 0141", rd_seen); end
        checks++; if (oen_low !== 17 * P) begin failures++; $display("FAIL read_oen_window: got %0d expected %0d", oen_low, 17 * P); end
        checks++; if (mdio_oen !== 1'b1 || pulse_err !== 0) begin failures++; $display("FAIL read_release: got oen=%b perr=%0d expected 1 0", mdio_oen, pulse_err); end
    endtask

    task automatic test_other_phy();
        int e_wr, e_rd;
        mem[9] = 16'h1234;
        model(32, MDIO_OP_READ, 5'd3, e_wr, e_rd);
        run_frame(1'b1, 32, MDIO_OP_READ, 5'd3, 5'h09, 16'h0, -1);
        checks++; if (rd_cnt !== 0 || oen_low !== 0) begin failures++; $display("FAIL other_phy_quiet: got rd=%0d oen_low=%0d expected 0 0", rd_cnt, oen_low); end
        checks++; if (rd_seen !== 16'hFFFF) begin failures++; $display("FAIL other_phy_line: got %h expected ffff", rd_seen); end
        model(32, MDIO_OP_WRITE, 5'd1, e_wr, e_rd);
        run_frame(1'b1, 32, MDIO_OP_WRITE, 5'd1, 5'h07, 16'h5A0F, -1);
        checks++; if (wr_cnt !== 1 || wr_data !== 16'h5A0F || wr_addr !== 5'h07) begin failures++; $display("FAIL after_other_phy: got wr=%0d %h@%h expected 1 5a0f@07", wr_cnt, wr_data, wr_addr); end
    endtask

    task automatic test_bad_frames();
        int e_wr, e_rd;
        do_reset();
        model(31, MDIO_OP_WRITE, 5'd1, e_wr, e_rd);
        run_frame(1'b1, 31, MDIO_OP_WRITE, 5'd1, 5'h05, 16'hFFFF, -1);
        checks++; if (wr_cnt !== 0 || rd_cnt !== 0) begin failures++; $display("FAIL short_preamble: got wr=%0d rd=%0d expected 0 0", wr_cnt, rd_cnt); end
        model(32, 2'b11, 5'd1, e_wr, e_rd);
        run_frame(1'b1, 32, 2'b11, 5'd1, 5'h05, 16'hFFFF, -1);
        checks++; if (wr_cnt !== 0 || rd_cnt !== 0 || oen_low !== 0) begin failures++; $display("FAIL bad_opcode: got wr=%0d rd=%0d oen_low=%0d expected 0 0 0", wr_cnt, rd_cnt, oen_low); end
    endtask

    task automatic test_reset_midframe();
        int e_wr, e_rd;
        mem[6] = 16'hC3C3;
        run_frame(1'b1, 32, MDIO_OP_READ, 5'd1, 5'h06, 16'h0, 23);
        checks++; if (oen_before !== 1'b0) begin failures++; $display("FAIL rst_rdata_driving: got %b expected 0", oen_before); end
        checks++; if (oen_after !== 1'b1) begin failures++; $display("FAIL rst_rdata_release: got %b expected 1", oen_after); end
        model(32, MDIO_OP_WRITE, 5'd1, e_wr, e_rd);
        run_frame(1'b1, 32, MDIO_OP_WRITE, 5'd1, 5'h11, 16'h8001, -1);
        checks++; if (wr_cnt !== 1 || wr_data !== 16'h8001) begin failures++; $display("FAIL after_rst_rdata: got wr=%0d %h expected 1 8001", wr_cnt, wr_data); end
        run_frame(1'b1, 32, MDIO_OP_WRITE, 5'd1, 5'h12, 16'h7777, 24);
        checks++; if (wr_cnt !== 0 || reg_wdata !== 16'h0) begin failures++; $display("FAIL rst_wdata: got wr=%0d wdata=%h expected 0 0000", wr_cnt, reg_wdata); end
        mem[12] = 16'h9E71;
        model(32, MDIO_OP_READ, 5'd1, e_wr, e_rd);
        run_frame(1'b1, 32, MDIO_OP_READ, 5'd1, 5'h0C, 16'h0, -1);
        checks++; if (rd_cnt !== 1 || rd_seen !== 16'h9E71) begin failures++; $display("FAIL after_rst_wdata: got rd=%0d %h expected 1 9e71", rd_cnt, rd_seen); end
    endtask

    task automatic test_back_to_back();
        int e_wr, e_rd;
        do_reset();
        model(32, MDIO_OP_WRITE, 5'd1, e_wr, e_rd);
        run_frame(1'b1, 32, MDIO_OP_WRITE, 5'd1, 5'h01, 16'h1111, -1);
        checks++; if (wr_cnt !== 1) begin failures++; $display("FAIL b2b_first: got %0d expected 1", wr_cnt); end
        model(1, MDIO_OP_WRITE, 5'd1, e_wr, e_rd);
        run_frame(1'b0, 1, MDIO_OP_WRITE, 5'd1, 5'h01, 16'h2222, -1);
        checks++; if (wr_cnt !== (SUP ? 1 : 0) || wr_cnt !== e_wr) begin failures++; $display("FAIL b2b_second: got %0d expected %0d", wr_cnt, SUP ? 1 : 0); end
    endtask

    task automatic test_random();
        int e_wr, e_rd, npre, sel;
        logic [1:0] op;
        logic [4:0] phy, ra;
        logic [15:0] wd;
        for (int n = 0; n < 12; n++) begin
            sel  = $urandom_range(0, 3);
            npre = (sel == 0) ? PMIN - 1 : PMIN + $urandom_range(0, 4);
            sel  = $urandom_range(0, 7);
            op   = (sel < 3) ? MDIO_OP_READ : (sel < 6) ? MDIO_OP_WRITE : 2'($urandom_range(0, 3));
            phy  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : MYPHY;
            ra   = 5'($urandom_range(0, 31));
            wd   = 16'($urandom);
            mem[ra] = 16'($urandom);
            model(npre, op, phy, e_wr, e_rd);
            run_frame(1'b1, npre, op, phy, ra, wd, -1);
            checks++; if (wr_cnt !== e_wr || rd_cnt !== e_rd) begin failures++; $display("FAIL rnd%0d_strobes: got wr=%0d rd=%0d expected %0d %0d", n, wr_cnt, rd_cnt, e_wr, e_rd); end
            if (e_wr == 1) begin
                checks++; if (wr_addr !== ra || wr_data !== wd) begin failures++; $display("FAIL rnd%0d_write: got %h@%h expected %h@%h", n, wr_data, wr_addr, wd, ra); end
            end
            if (e_rd == 1) begin
                checks++; if (rd_seen !== mem[ra] || ta_seen !== 1'b0) begin failures++; $display("FAIL rnd%0d_read: got %h ta=%b expected %h ta=0", n, rd_seen, ta_seen, mem[ra]); end
            end
            checks++; if (oen_low !== ((e_rd == 1) ? 17 * P : 0) || pulse_err !== 0) begin failures++; $display("FAIL rnd%0d_oen: got oen_low=%0d perr=%0d expected %0d 0", n, oen_low, pulse_err, (e_rd == 1) ? 17 * P : 0); end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
        test_reset();
        test_write();
        test_read();
        test_other_phy();
        test_bad_frames();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdio_responder.md
# mdio_responder

PHY-side Clause-22 MDIO management responder: the far end of the MAC's MDC/MDIO master. It oversamples MDC and MDIO on the system clock, decodes read and write frames addressed to its PHY address, and exposes a single-cycle register-access port to local logic. It drives MDIO only during the read-data phase. It sits between the board-level MDIO pins (or the MAC's `mdio_out`/`mdio_oen` in loopback) and the local status/control register bank.

## Interface
- `PHY_ADDR`, default 5'd1: PHY address this responder answers to.
- `PREAMBLE_MIN`, default 32: number of consecutive ones required before a start-of-frame is accepted.
- `clk_clk` input 1: system clock, at least 20× MDC frequency.
- `reset_reset_n` input 1: asynchronous, active-low reset.
- `mdio_mdc` input 1: management clock from the master; asynchronous to `clk_clk`.
- `mdio_in` input 1: MDIO pin value, asynchronous.
- `mdio_out` output 1: MDIO drive value.
- `mdio_oen` output 1: MDIO output enable, active low; 1 = released.
- `reg_addr` output 5: register address of the current access.
- `reg_wdata` output 16: write data.
- `reg_wr` output 1: one-`clk_clk` write strobe.
- `reg_rd` output 1: one-`clk_clk` read request strobe.
- `reg_rdata` input 16: read data, valid no later than 4 `clk_clk` after `reg_rd`.

## Operation
- MDC and MDIO pass through identical 2-flop synchronizers. An MDC rising edge is detected from the synchronized value as previous 0, current 1, giving an internal `bit_en` pulse. All frame decoding advances only on `bit_en`, sampling the synchronized MDIO value.
- States: IDLE, START, OP, PHYAD, REGAD, TA, WDATA, RDATA, SKIP.
- IDLE:
  - A preamble counter counts consecutive sampled ones and saturates at `PREAMBLE_MIN`.
  - A sampled 0 with the counter saturated enters START. A sampled 0 below saturation clears the counter.
- START: the next bit must be 1, otherwise return to IDLE with the counter cleared.
- OP: shift 2 bits. 10 = read, 01 = write. 00 or 11 returns to IDLE.
- PHYAD: shift 5 bits, MSB first.
- REGAD: shift 5 bits.
  - On the last bit, latch `reg_addr`.
  - If PHYAD ≠ `PHY_ADDR`, go to SKIP for 18 bits, then IDLE, never driving MDIO.
  - On a matching read, pulse `reg_rd` in the same cycle the last REGAD bit is sampled.
- TA:
  - Read:
    - On the edge sampling the first TA bit, capture `reg_rdata` into the shift register.
    - On the same edge, assert `mdio_oen`=0 with `mdio_out`=0; this is the second TA bit.
  - Write: ignore both TA bits.
- WDATA: shift 16 bits. After the 16th, update `reg_wdata` and pulse `reg_wr` for 1 cycle, then return to IDLE.
- RDATA:
  - On each `bit_en`, present the next bit, D15 first.
  - On the edge that samples D0, set `mdio_oen`=1, then return to IDLE.
- Preamble counter behaviour at frame end:
  - After any frame, the counter restarts from 0.
  - Back-to-back frames therefore each need a full preamble (except with the configuration macro below).

## Timing
- Reset values:
  - `mdio_oen`=1, `mdio_out`=1, `reg_addr`=0, `reg_wdata`=0, `reg_wr`=0, `reg_rd`=0.
  - State = IDLE, counters = 0.
- An MDC pin edge becomes `bit_en` 3 `clk_clk` later. MDIO output updates on the cycle after `bit_en`, so pin-to-drive latency is 4 `clk_clk`. At 50 MHz that is 80 ns, inside the 300 ns Clause-22 window.
- `reg_wr` and `reg_rd` are exactly one cycle wide, never simultaneous, at most one per frame.
- Reset asserted mid-frame immediately releases MDIO (`mdio_oen`=1) and discards any partial write; no `reg_wr` is issued.
- Noise: MDC glitches shorter than 1 `clk_clk` may be lost; this is intended.

## Configuration
- `MDIO_RESPONDER_PREAMBLE_SUPPRESS_EN`:
  - Defined: after a completed matching frame, only 1 idle one is required before the next start; the first frame after reset still needs `PREAMBLE_MIN`.
  - Undefined: every frame requires `PREAMBLE_MIN` ones.

## Structure
- Package `mdio_pkg`:
  - State enum.
  - Opcode constants `MDIO_OP_READ`=2'b10 and `MDIO_OP_WRITE`=2'b01.
  - Start constant `MDIO_ST`=2'b01.
  - Field widths (PHYAD/REGAD 5, data 16).
- Sub-module `mdio_sync`: synchronizes MDC and MDIO with identical 2-flop chains and produces the `bit_en` rising-edge pulse with the aligned MDIO sample.

## Test plan
- 32 ones, write frame PHYAD=1, REGAD=0x04, data 0xA5C3 → one `reg_wr` pulse with `reg_addr`=0x04, `reg_wdata`=0xA5C3; `mdio_oen` stays 1 throughout.
- Read frame PHYAD=1, REGAD=0x02, `reg_rdata`=0x0141 →
  - one `reg_rd` pulse;
  - `mdio_oen`=0 from the second TA bit through D0;
  - master samples TA=0 then 0x0141;
  - `mdio_oen`=1 after D0.
- Read to PHYAD=3 → no `reg_rd`, `mdio_oen` stays 1; the next valid frame to PHYAD=1 is decoded normally.
- 31 ones then start → frame ignored. Opcode 11 after a valid preamble → return to IDLE, no strobes.
- Reset asserted during RDATA bit D8 → `mdio_oen`=1 within 1 cycle. Reset during WDATA → no `reg_wr`. Both are followed by a correct subsequent frame.
- With `MDIO_RESPONDER_PREAMBLE_SUPPRESS_EN`: two write frames separated by 1 idle one → two `reg_wr` pulses. Without the macro → only the first.
